// File: rtl/div_if.sv
`default_nettype none
// div_if: operand/result handshake between the execute stage and div_seq.
interface div_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// div_seq: 32-cycle restoring DIV/DIVU producing {remainder, quotient}.
// Define DIV_ZERO_FAST_EN to short-circuit divide-by-zero through a ZERO state.
module div_seq (
  input wire logic clk,
  input wire logic resetn,
  div_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] dvd_q;   // dividend magnitude shifts out MSB-first, quotient bits shift in
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [63:0] result_q;
  logic        ready_q;

  logic [31:0] mag1_d;
  logic [31:0] mag2_d;
  logic [32:0] shift_d;
  logic        ge_d;
  logic [31:0] diff_d;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] qfix_d;
  logic [31:0] rfix_d;
  logic        accept_d;

  always_comb begin
    mag1_d   = (bus.signed_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2_d   = (bus.signed_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
    shift_d  = {rem_q, dvd_q[31]};
    ge_d     = (shift_d >= {1'b0, dvs_q});
    diff_d   = shift_d[31:0] - dvs_q;
    rem_d    = ge_d ? diff_d : shift_d[31:0];
    quo_d    = {dvd_q[30:0], ge_d};
    qfix_d   = qneg_q ? -quo_d : quo_d;
    rfix_d   = rneg_q ? -rem_d : rem_d;
    accept_d = (state_q == IDLE) && bus.start_i && !bus.annul_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      // The pulse follows the DONE cycle even if that cycle is annulled.
      ready_q <= (state_q == DONE);
      if (bus.annul_i) begin
        state_q <= IDLE;
        cnt_q   <= 6'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept_d) begin
              dvd_q  <= mag1_d;
              dvs_q  <= mag2_d;
              rem_q  <= 32'd0;
              cnt_q  <= 6'd0;
              qneg_q <= bus.signed_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
              rneg_q <= bus.signed_i && bus.opdata1_i[31];
`ifdef DIV_ZERO_FAST_EN
              state_q <= (bus.opdata2_i == 32'd0) ? ZERO : BUSY;
`else
              state_q <= BUSY;
`endif
            end
          end
          BUSY: begin
            rem_q <= rem_d;
            dvd_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              result_q <= {rfix_d, qfix_d};
              state_q  <= DONE;
            end
          end
`ifdef DIV_ZERO_FAST_EN
          ZERO: begin
            result_q <= {(rneg_q ? -dvd_q : dvd_q), 32'hFFFF_FFFF};
            state_q  <= DONE;
          end
`endif
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.stall_o  = accept_d || (state_q == BUSY) || (state_q == ZERO);

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// tb_div_seq: random + directed DIV/DIVU traffic checked against an arithmetic model.
module tb_div_seq;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_if bus();

  div_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  bit          model_ok = 1'b0;
  bit          inflight = 1'b0;
  longint      t_ready = 0;
  logic [63:0] res_m = 64'd0;
  bit          res_known = 1'b1;
  logic [63:0] pend_m = 64'd0;
  bit          pend_known = 1'b1;
  logic [64:0] m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Returns {known, remainder, quotient} from plain integer division.
  function automatic logic [64:0] model_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      return {1'b1, a, 32'hFFFF_FFFF};
`else
      return {1'b0, 64'd0};
`endif
    end
    if (sg) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b1, r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  // One clock: apply inputs, check stall, advance the model across the edge, check outputs.
  task automatic step(input bit st, input bit sg, input logic [31:0] a, input logic [31:0] b,
                      input bit an, input bit rn);
    bit          busy_now;
    logic [64:0] mm;
    bus.start_i   = st;
    bus.signed_i  = sg;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.annul_i   = an;
    resetn        = rn;
    #1;
    busy_now = inflight && (cyc < t_ready);
    if (model_ok)
      chk("stall", {63'd0, bus.stall_o},
          {63'd0, (!busy_now && st && !an) || (inflight && cyc < t_ready - 1)});
    @(posedge clk);
    if (!rn) begin
      inflight  = 1'b0;
      res_m     = 64'd0;
      res_known = 1'b1;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (inflight && (cyc + 1 < t_ready) && an) begin
        inflight = 1'b0;
      end else if (inflight && (cyc + 1 == t_ready - 1)) begin
        res_m     = pend_m;
        res_known = pend_known;
      end
      if (st && !an && !busy_now) begin
        mm         = model_div(sg, a, b);
        pend_m     = mm[63:0];
        pend_known = mm[64];
        t_ready    = cyc + 1 + latency(b);
        inflight   = 1'b1;
      end
    end
    cyc++;
    #1;
    if (model_ok) begin
      chk("ready", {63'd0, bus.ready_o}, {63'd0, inflight && (cyc == t_ready)});
      if (res_known) chk("result", bus.result_o, res_m);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    bit          st, sg, an, rn;
    logic [31:0] a, b;
    int          sel;

    repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_ready", {63'd0, bus.ready_o}, 64'd0);

    m = model_div(1'b0, 32'd100, 32'd7);
    chk("model_divu_100_7", m[63:0], {32'd2, 32'd14});
    m = model_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("model_div_m7_2", m[63:0], {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    m = model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("model_div_min_m1", m[63:0], {32'h0, 32'h8000_0000});
    m = model_div(1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("model_divu_max_1", m[63:0], {32'h0, 32'hFFFF_FFFF});

    step(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
    idle(35);
    chk("divu_100_7", bus.result_o, {32'd2, 32'd14});

    step(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 32'd9, 32'd3, 1'b0, 1'b1);
    idle(4);
    chk("div_m7_2", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    step(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle(33);
    chk("ready_at_33", {63'd0, bus.ready_o}, 64'd1);
    chk("div_min_m1", bus.result_o, {32'h0, 32'h8000_0000});
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    idle(35);
    chk("divu_max_1", bus.result_o, {32'h0, 32'hFFFF_FFFF});

    step(1'b1, 1'b0, 32'h1234_5678, 32'd99, 1'b0, 1'b1);
    idle(9);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(40);
    chk("annul_held", bus.result_o, {32'h0, 32'hFFFF_FFFF});
    step(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b1);
    idle(35);
    chk("after_annul", bus.result_o, {32'd1, 32'd333});

    step(1'b1, 1'b0, 32'd500, 32'd5, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("midbusy_rst_result", bus.result_o, 64'd0);
    chk("midbusy_rst_ready", {63'd0, bus.ready_o}, 64'd0);
    idle(40);

    step(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b1);
    idle(35);
`ifdef DIV_ZERO_FAST_EN
    chk("divu_5_0_fast", bus.result_o, {32'd5, 32'hFFFF_FFFF});
`endif

    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      sg  = $urandom_range(0, 1);
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        4:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      an = ($urandom_range(0, 99) == 0);
      rn = ($urandom_range(0, 299) != 0);
      step(st, sg, a, b, an, rn);
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-003 The block SHALL have port start_i, input, 1 bit: request a DIV/DIVU; sampled only in IDLE.
REQ-004 The block SHALL have port signed_i, input, 1 bit: 1 = DIV (signed), 0 = DIVU; sampled with start_i.
REQ-005 The block SHALL have port opdata1_i, input, 32 bits: dividend; sampled with start_i.
REQ-006 The block SHALL have port opdata2_i, input, 32 bits: divisor; sampled with start_i.
REQ-007 The block SHALL have port annul_i, input, 1 bit: flush from exception/branch; aborts any operation.
REQ-008 The block SHALL have port result_o, output, 64 bits: {remainder, quotient}, driven directly to hilo_out (hi = remainder, lo = quotient).
REQ-009 The block SHALL have port ready_o, output, 1 bit: result valid, high for exactly one cycle.
REQ-010 The block SHALL have port stall_o, output, 1 bit: pipeline stall request.

Function
REQ-011 The block SHALL implement the states IDLE, BUSY and DONE (plus ZERO when DIV_ZERO_FAST_EN is defined).
REQ-012 IDLE SHALL go to BUSY on start_i=1 and annul_i=0; the operands, signed_i and a 6-bit iteration counter cleared to 0 SHALL be latched on that edge.
REQ-013 In signed mode the block SHALL convert negative operands to magnitude at latch time; 0x80000000 SHALL be handled as magnitude 2^31 with no overflow.
REQ-014 BUSY SHALL perform one restoring shift-subtract step per cycle on a 33-bit partial remainder and SHALL advance to DONE after exactly 32 steps (counter = 31 -> DONE).
REQ-015 In signed mode the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign; this fixup SHALL be applied on the BUSY->DONE edge.
REQ-016 In DONE the block SHALL assert ready_o=1 for one cycle and then return to IDLE.
REQ-017 With start_i sampled at edge N, ready_o SHALL be high during the cycle following edge N+33.
REQ-018 result_o SHALL be registered, SHALL update only on entry to DONE, and SHALL hold its value until the next DONE.
REQ-019 stall_o SHALL equal (IDLE and start_i and not annul_i) or BUSY or ZERO, and SHALL be low in DONE so that the stage advances with ready_o.
REQ-020 start_i SHALL be ignored in BUSY, ZERO and DONE; there is no queueing.
REQ-021 annul_i=1 in any state SHALL force IDLE on the next edge, with ready_o=0 and result_o unchanged.
REQ-022 annul_i=1 in DONE SHALL take priority over start_i; the ready_o value in that cycle is still 1 and the consumer discards it.
REQ-023 Back-to-back start_i in the cycle after DONE SHALL be accepted (IDLE -> BUSY).

Reset
REQ-024 While resetn=0 at an edge, the block SHALL set state = IDLE, counter = 0, result_o = 0, ready_o = 0 and the internal operands to 0.
REQ-025 Reset SHALL take priority over annul_i and start_i.
REQ-026 Reset during BUSY SHALL abandon the operation and produce no ready_o pulse.
REQ-027 stall_o SHALL be 0 in the first cycle after reset unless start_i=1.

Configuration
REQ-028 The macro DIV_ZERO_FAST_EN SHALL select the divide-by-zero behaviour.
REQ-029 With DIV_ZERO_FAST_EN defined, start_i with opdata2_i = 0 SHALL go IDLE -> ZERO -> DONE, with ready_o in the cycle after edge N+2 and result_o = {opdata1_i, 32'hFFFFFFFF}.
REQ-030 With DIV_ZERO_FAST_EN undefined, a divisor of 0 SHALL take the normal 33-edge path, and its result value SHALL be architecturally UNPREDICTABLE and not checked.

Verification
REQ-031 DIVU 100 / 7 -> ready_o after 33 edges, result_o = {32'd2, 32'd14}, stall_o high for 33 cycles.
REQ-032 DIV -7 / 2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD} (remainder -1, quotient -3).
REQ-033 DIV 0x80000000 / -1 -> result_o = {32'h0, 32'h80000000}, no hang; DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
REQ-034 annul_i pulsed at BUSY cycle 10 -> IDLE next edge, no ready_o, prior result_o held; a new start_i is then accepted normally.
REQ-035 resetn=0 mid-BUSY -> all outputs 0 on the next edge; start_i held during BUSY is ignored (a single ready_o pulse only).
REQ-036 DIV_ZERO_FAST_EN defined, DIVU 5 / 0 -> ready_o after 2 edges, result_o = {32'd5, 32'hFFFFFFFF}.
